// File: rtl/vga_pattern_gen_if.sv
// rtl/vga_pattern_gen_if.sv - timing-in / pixel-out bundle for vga_pattern_gen
//
// Purpose: groups the raw VGA timing coming from the timing generator, the
// pattern select, and the re-aligned pixel outputs going to the VGA pins.
// Ports (signals):
//   hcount[9:0], vcount[9:0]  pixel column / line from timing generator
//   video_on                  active-video flag
//   hsync_in, vsync_in        raw syncs, active-low
//   mode[1:0]                 pattern select (taken at frame boundary)
//   hsync, vsync              syncs delayed to line up with rgb
//   rgb[2:0]                  pixel colour {r,g,b}
//   frame_tick                one-cycle pulse per frame
// Modports: master drives timing/mode (timing side), slave is the pattern stage.
interface vga_pattern_gen_if;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       video_on;
  logic       hsync_in;
  logic       vsync_in;
  logic [1:0] mode;
  logic       hsync;
  logic       vsync;
  logic [2:0] rgb;
  logic       frame_tick;

  modport master (
    output hcount, vcount, video_on, hsync_in, vsync_in, mode,
    input  hsync, vsync, rgb, frame_tick
  );

  modport slave (
    input  hcount, vcount, video_on, hsync_in, vsync_in, mode,
    output hsync, vsync, rgb, frame_tick
  );
endinterface

// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - VGA test-pattern source with 2-stage aligned sync path
//
// Purpose: turns raw timing into final rgb plus hsync/vsync delayed by the
// same two cycles. Patterns (mode latched at each vsync falling edge):
//   0 colour bars, 1 checkerboard, 2 bouncing box, 3 solid colour cycle.
// Ports:
//   clk25MHz  pixel clock
//   rst       asynchronous active-high reset
//   bus       vga_pattern_gen_if.slave (timing in, pixels/syncs/frame_tick out)
// Optional build macro: BORDER_EN - forces a one-pixel 111 frame on the
// outermost active rows/columns in every mode.
module vga_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int BOX_SIZE = 32,
  parameter int BOX_STEP = 2
) (
  input logic          clk25MHz,
  input logic          rst,
  vga_pattern_gen_if.slave bus
);

  localparam logic [9:0] MAX_X = 10'(H_ACTIVE - BOX_SIZE);
  localparam logic [9:0] MAX_Y = 10'(V_ACTIVE - BOX_SIZE);
  localparam int         BAR_W = H_ACTIVE / 8;

  // stage 1 copies of the raw timing
  logic [9:0] h1, v1;
  logic       von1, hs1, vs1;
  // set once any post-reset vsync sample exists, so the reset value of vs1
  // can never pair with a low vsync_in to fake a frame boundary
  logic       armed;

  // frame-rate state
  logic [1:0] mode_q;
  logic [7:0] frame_cnt;
  logic [9:0] box_x, box_y;
  logic       neg_x, neg_y;   // 1 = moving towards 0

  // stage 2 outputs
  logic       hsync_q, vsync_q, tick_q;
  logic [2:0] rgb_q;

  logic       boundary;
  logic [10:0] nxt_x, nxt_y;
  logic [2:0] bar;
  logic [2:0] pix_rgb;
  logic       in_box;

  assign boundary = armed & vs1 & ~bus.vsync_in;

  // Returns {neg_next, pos_next}; clamps at the edges instead of overshooting.
  function automatic logic [10:0] bounce(input logic [9:0] pos,
                                         input logic       neg,
                                         input logic [9:0] lim);
    logic [10:0] up;
    up = {1'b0, pos} + 11'(BOX_STEP);
    if (!neg) begin
      if (up >= {1'b0, lim}) return {1'b1, lim};
      else                   return {1'b0, up[9:0]};
    end else begin
      if (pos <= 10'(BOX_STEP)) return {1'b0, 10'd0};
      else                      return {1'b1, pos - 10'(BOX_STEP)};
    end
  endfunction

  always_comb begin
    nxt_x = bounce(box_x, neg_x, MAX_X);
    nxt_y = bounce(box_y, neg_y, MAX_Y);
  end

  always_ff @(posedge clk25MHz or posedge rst) begin
    if (rst) begin
      h1    <= '0;
      v1    <= '0;
      von1  <= 1'b0;
      hs1   <= 1'b1;
      vs1   <= 1'b1;
      armed <= 1'b0;
    end else begin
      h1    <= bus.hcount;
      v1    <= bus.vcount;
      von1  <= bus.video_on;
      hs1   <= bus.hsync_in;
      vs1   <= bus.vsync_in;
      armed <= 1'b1;
    end
  end

  always_ff @(posedge clk25MHz or posedge rst) begin
    if (rst) begin
      tick_q    <= 1'b0;
      mode_q    <= 2'd0;
      frame_cnt <= 8'd0;
      box_x     <= '0;
      box_y     <= '0;
      neg_x     <= 1'b0;
      neg_y     <= 1'b0;
    end else begin
      tick_q <= boundary;
      if (boundary) begin
        mode_q    <= bus.mode;
        frame_cnt <= frame_cnt + 8'd1;
        {neg_x, box_x} <= nxt_x;
        {neg_y, box_y} <= nxt_y;
      end
    end
  end

  // bar index by compare chain on the stage-1 column
  always_comb begin
    bar = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (h1 >= 10'(i * BAR_W)) bar = 3'(i);
    end
  end

  always_comb begin
    in_box = ({1'b0, h1} >= {1'b0, box_x}) &&
             ({1'b0, h1} <  {1'b0, box_x} + 11'(BOX_SIZE)) &&
             ({1'b0, v1} >= {1'b0, box_y}) &&
             ({1'b0, v1} <  {1'b0, box_y} + 11'(BOX_SIZE));
  end

  always_comb begin
    pix_rgb = 3'b000;
    if (von1) begin
      case (mode_q)
        // bars 111,110,011,010,101,100,001,000 reduce to inverted index bits
        2'd0:    pix_rgb = {~bar[1], ~bar[2], ~bar[0]};
        2'd1:    pix_rgb = (h1[5] ^ v1[5]) ? 3'b111 : 3'b000;
        2'd2:    pix_rgb = in_box ? 3'b111 : 3'b001;
        default: pix_rgb = frame_cnt[7:5];
      endcase
`ifdef BORDER_EN
      if (h1 == 10'd0 || h1 == 10'(H_ACTIVE - 1) ||
          v1 == 10'd0 || v1 == 10'(V_ACTIVE - 1)) begin
        pix_rgb = 3'b111;
      end
`endif
    end
  end

  always_ff @(posedge clk25MHz or posedge rst) begin
    if (rst) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      rgb_q   <= 3'b000;
    end else begin
      hsync_q <= hs1;
      vsync_q <= vs1;
      rgb_q   <= pix_rgb;
    end
  end

  assign bus.hsync      = hsync_q;
  assign bus.vsync      = vsync_q;
  assign bus.rgb        = rgb_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb/tb_vga_pattern_gen.sv - self-checking bench for vga_pattern_gen
module tb_vga_pattern_gen;
  localparam int HA = 640;
  localparam int VA = 480;
  localparam int BS = 32;
  localparam int ST = 2;
`ifdef BORDER_EN
  localparam bit BORDER_ON = 1'b1;
`else
  localparam bit BORDER_ON = 1'b0;
`endif

  logic clk25MHz = 1'b0;
  logic rst = 1'b1;
  always #20 clk25MHz = ~clk25MHz;

  vga_pattern_gen_if bus ();

  vga_pattern_gen #(.H_ACTIVE(HA), .V_ACTIVE(VA), .BOX_SIZE(BS), .BOX_STEP(ST)) dut (
    .clk25MHz(clk25MHz),
    .rst     (rst),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail = 0;

  int bar_col[8] = '{7, 6, 3, 2, 5, 4, 1, 0};

  // reference state: history of applied inputs and frames since reset
  bit       have_prev;
  int       prev_h, prev_v;
  bit       prev_von, prev_hs, prev_vs;
  int       nframes;
  int       mode_ref;

  typedef struct {
    bit [1:0] md;
    int       h;
    int       v;
    int       exp_rgb;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // triangle wave position: n steps of ST between 0 and span
  function automatic int tri_pos(int n, int span);
    int m, p;
    m = span / ST;
    p = n % (2 * m);
    return ST * ((p <= m) ? p : 2 * m - p);
  endfunction

  function automatic int ref_pix(int h, int v, bit von, int md, int nf);
    int bx, by;
    if (!von) return 0;
    if (BORDER_ON && (h == 0 || h == HA - 1 || v == 0 || v == VA - 1)) return 7;
    case (md)
      0: return bar_col[h / (HA / 8)];
      1: return (((h / 32) + (v / 32)) % 2 != 0) ? 7 : 0;
      2: begin
        bx = tri_pos(nf, HA - BS);
        by = tri_pos(nf, VA - BS);
        return (h >= bx && h < bx + BS && v >= by && v < by + BS) ? 7 : 1;
      end
      default: return (nf % 256) / 32;
    endcase
  endfunction

  // one pixel clock: drive at negedge, check 1ns after the rising edge
  task automatic cyc(input logic [9:0] h, input logic [9:0] v, input bit hs,
                     input bit vs, input logic [1:0] md);
    bit von;
    int e_rgb;
    bit e_tick;
    von = (h < 10'(HA)) && (v < 10'(VA));
    @(negedge clk25MHz);
    bus.hcount   = h;
    bus.vcount   = v;
    bus.video_on = von;
    bus.hsync_in = hs;
    bus.vsync_in = vs;
    bus.mode     = md;
    @(posedge clk25MHz);
    #1;
    e_rgb  = have_prev ? ref_pix(prev_h, prev_v, prev_von, mode_ref, nframes) : 0;
    e_tick = have_prev && prev_vs && !vs;
    chk("rgb", 32'(bus.rgb), 32'(e_rgb));
    chk("hsync", 32'(bus.hsync), 32'(have_prev ? prev_hs : 1'b1));
    chk("vsync", 32'(bus.vsync), 32'(have_prev ? prev_vs : 1'b1));
    chk("frame_tick", 32'(bus.frame_tick), 32'(e_tick));
    if (e_tick) begin
      nframes++;
      mode_ref = int'(md);
    end
    have_prev = 1'b1;
    prev_h = int'(h);
    prev_v = int'(v);
    prev_von = von;
    prev_hs = hs;
    prev_vs = vs;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_hsync"}, 32'(bus.hsync), 32'd1);
    chk({tag, "_vsync"}, 32'(bus.vsync), 32'd1);
    chk({tag, "_rgb"}, 32'(bus.rgb), 32'd0);
    chk({tag, "_tick"}, 32'(bus.frame_tick), 32'd0);
  endtask

  // asynchronous assert mid-cycle, release just after a rising edge
  task automatic do_reset();
    @(negedge clk25MHz);
    bus.hcount = 10'd300;
    bus.video_on = 1'b1;
    bus.hsync_in = 1'b0;
    bus.vsync_in = 1'b0;
    #5 rst = 1'b1;
    #1 chk_reset_outputs("rst_async");
    repeat (2) @(posedge clk25MHz);
    #1 chk_reset_outputs("rst_hold");
    #1 rst = 1'b0;
    have_prev = 1'b0;
    nframes = 0;
    mode_ref = 0;
  endtask

  // short synthetic frame: box-edge probes, border probes, random pixels,
  // then a vsync low pulse that produces exactly one boundary
  task automatic frame(input logic [1:0] md, input int nrand);
    int bx, by;
    bx = tri_pos(nframes, HA - BS);
    by = tri_pos(nframes, VA - BS);
    cyc(10'(bx), 10'(by), 1'b1, 1'b1, md);
    cyc(10'(bx + BS - 1), 10'(by + BS - 1), 1'b1, 1'b1, md);
    cyc(10'(bx + BS), 10'(by), 1'b1, 1'b1, md);
    cyc(10'(bx), 10'(by + BS), 1'b1, 1'b1, md);
    cyc(10'(bx - 1), 10'(by), 1'b1, 1'b1, md);
    cyc(10'd0, 10'd100, 1'b1, 1'b1, md);
    cyc(10'(HA - 1), 10'd100, 1'b1, 1'b1, md);
    for (int i = 0; i < nrand; i++) begin
      cyc(10'($urandom_range(0, 700)), 10'($urandom_range(0, 500)),
          1'($urandom_range(0, 1)), 1'b1, md);
    end
    cyc(10'd700, 10'd490, 1'b1, 1'b0, md);
    cyc(10'd700, 10'd491, 1'b1, 1'b0, md);
    cyc(10'd700, 10'd492, 1'b1, 1'b1, md);
  endtask

  initial begin
    bus.hcount = '0;
    bus.vcount = '0;
    bus.video_on = 1'b0;
    bus.hsync_in = 1'b0;
    bus.vsync_in = 1'b0;
    bus.mode = 2'd0;
    have_prev = 1'b0;
    nframes = 0;
    mode_ref = 0;

    tbl.push_back('{2'd0, 0, 10, 7});
    tbl.push_back('{2'd0, 79, 10, 7});
    tbl.push_back('{2'd0, 80, 10, 6});
    tbl.push_back('{2'd0, 159, 10, 6});
    tbl.push_back('{2'd0, 160, 10, 3});
    tbl.push_back('{2'd0, 240, 10, 2});
    tbl.push_back('{2'd0, 320, 10, 5});
    tbl.push_back('{2'd0, 400, 10, 4});
    tbl.push_back('{2'd0, 480, 10, 1});
    tbl.push_back('{2'd0, 560, 10, 0});
    tbl.push_back('{2'd0, 639, 10, BORDER_ON ? 7 : 0});
    tbl.push_back('{2'd0, 0, 100, 7});
    tbl.push_back('{2'd1, 0, 0, BORDER_ON ? 7 : 0});
    tbl.push_back('{2'd1, 32, 0, 7});
    tbl.push_back('{2'd1, 32, 32, 0});
    tbl.push_back('{2'd1, 64, 32, 7});
    tbl.push_back('{2'd1, 5, 40, 7});
    tbl.push_back('{2'd1, 639, 100, BORDER_ON ? 7 : 0});
    tbl.push_back('{2'd1, 0, 100, 7});

    // power-on reset with vsync held low at release: no tick until a real edge
    do_reset();
    for (int i = 0; i < 5; i++) cyc(10'(100 + i), 10'd20, 1'b1, 1'b0, 2'd1);
    for (int i = 0; i < 4; i++) cyc(10'(200 + i), 10'd20, 1'b0, 1'b1, 2'd1);

    // table-driven pixel checks
    foreach (tbl[k]) begin
      if (int'(tbl[k].md) != mode_ref) frame(tbl[k].md, 0);
      cyc(10'(tbl[k].h), 10'(tbl[k].v), 1'b1, 1'b1, tbl[k].md);
      cyc(10'd700, 10'd10, 1'b1, 1'b1, tbl[k].md);
      chk($sformatf("tbl%0d_rgb", k), 32'(bus.rgb), 32'(tbl[k].exp_rgb));
    end

    // mode 0 full line sweep including blanking and hsync pulse
    frame(2'd0, 0);
    for (int h = 0; h < 680; h++) cyc(10'(h), 10'd10, !(h >= 656 && h < 670), 1'b1, 2'd0);

    // mode request changes to 2 at line 200: bars persist until the boundary
    for (int h = 0; h < 640; h += 7) cyc(10'(h), 10'd199, 1'b1, 1'b1, 2'd0);
    for (int h = 0; h < 640; h += 7) cyc(10'(h), 10'd200, 1'b1, 1'b1, 2'd2);
    frame(2'd2, 4);
    chk("mode_after_switch", 32'(mode_ref), 32'd2);

    // randomized timing, syncs and mode requests
    for (int i = 0; i < 400; i++) begin
      cyc(10'($urandom_range(0, 799)), 10'($urandom_range(0, 524)),
          1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0),
          2'($urandom_range(0, 3)));
    end

    // reset mid-frame, then a long bouncing-box run past both wall hits
    do_reset();
    for (int f = 0; f < 312; f++) frame(2'd2, 2);

    // reset again, colour cycle over more than 64 frames
    do_reset();
    for (int f = 0; f < 68; f++) frame(2'd3, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
Pixel-source stage directly upstream of the VGA output pins. Consumes raw timing (pixel coordinates, active-video flag, sync pulses) from the 25 MHz VGA timing generator and produces the final 3-bit rgb plus re-aligned hsync/vsync. Provides four selectable test patterns, including an animated bouncing box, for bring-up of monitors and the clocking path.

Parameters:
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines per frame
BOX_SIZE, 32, bouncing-box edge length in pixels
BOX_STEP, 2, box displacement per frame on each axis

Ports:
clk25MHz  input  1  pixel clock
rst  input  1  asynchronous active-high reset
hcount  input  10  current pixel column from timing generator
vcount  input  10  current line from timing generator
video_on  input  1  high when hcount<H_ACTIVE and vcount<V_ACTIVE
hsync_in  input  1  horizontal sync, active-low
vsync_in  input  1  vertical sync, active-low
mode  input  2  pattern select; sampled only at frame boundary
hsync  output  1  hsync_in delayed to align with rgb
vsync  output  1  vsync_in delayed to align with rgb
rgb  output  3  pixel colour {r,g,b}
frame_tick  output  1  one-cycle pulse per frame

Behaviour:
- Single clock domain clk25MHz; rst asynchronous, active-high; all flops clear on rst.
- Reset values: hsync=1, vsync=1, rgb=0, frame_tick=0; internal mode_q=0, frame_cnt=0, box_x=0, box_y=0, dir_x=+, dir_y=+.
- Two-stage pipeline: S1 registers hcount, vcount, video_on, hsync_in, vsync_in; S2 registers computed rgb and the delayed syncs. Latency exactly 2 cycles input-to-output for rgb, hsync, vsync; all three stay mutually aligned.
- rgb=0 whenever video_on (S1 copy) is 0, irrespective of mode.
- Frame boundary: S1 vsync copy 1 followed by raw vsync_in 0 (falling edge). Next cycle: frame_tick=1 for exactly one cycle; mode_q<=mode; frame_cnt<=frame_cnt+1 (8-bit, wraps 255->0); box position updates.
- mode changes mid-frame have no effect until the next boundary; no partial-frame pattern tearing.
- Mode 0, colour bars: bar=hcount/80 (compare chain, no divider), bars 0..7 = 111,110,011,010,101,100,001,000.
- Mode 1, checkerboard: rgb = (hcount[5]^vcount[5]) ? 111 : 000 (32-px squares).
- Mode 2, bouncing box: pixel inside [box_x, box_x+BOX_SIZE) x [box_y, box_y+BOX_SIZE) -> 111, else 001.
- Mode 3, solid cycle: rgb=frame_cnt[7:5] (colour changes every 32 frames).
- Box update per axis (X shown; Y uses V_ACTIVE): max=H_ACTIVE-BOX_SIZE. If dir + and box_x+BOX_STEP>=max -> box_x=max, dir -. If dir - and box_x<=BOX_STEP -> box_x=0, dir +. Else box_x+=/-BOX_STEP. Clamp, never overshoot. Box animates in every mode; only mode 2 displays it.
- Corner hit: X and Y reverse independently on the same tick.
- Reset mid-frame: pipeline flushes; first valid rgb appears 2 cycles after rst deasserts; first frame_tick at next vsync falling edge.
- vsync_in held low at reset release: no frame_tick until a full high->low edge is seen.

Optional Feature:
BORDER_EN: when defined, any active pixel with hcount==0, hcount==H_ACTIVE-1, vcount==0 or vcount==V_ACTIVE-1 is forced to 111 in all modes, overriding the pattern (alignment check for monitor overscan). When undefined, no border logic is synthesised and patterns show unmodified to the edges.

Test Plan:
- rst=1 mid-line, release -> hsync=1, vsync=1, rgb=0, frame_tick=0 during reset; rgb valid exactly 2 cycles after first sampled pixel.
- mode=0, sweep line 10 -> hcount 0..79 gives 111, 80..159 gives 110, 560..639 gives 000; each value appears 2 cycles after its hcount; blanking gives 000.
- mode=1 -> (h=0,v=0)=000, (32,0)=111, (32,32)=000; hsync/vsync edges delayed exactly 2 cycles.
- mode switched 0->2 at line 200 -> bars continue to end of frame; box pattern starts after next frame_tick; frame_tick width is 1 cycle.
- mode=2, run 310 frames -> box_x reaches 608 at frame 304, then decrements by 2; box_y clamps at 448 then reverses; pixel (box_x, box_y)=111, (box_x+32, box_y)=001.
- mode=3, 64 frames -> rgb 000 for frames 0-31, 001 for frames 32-63; with BORDER_EN, pixel (0,100) and (639,100) = 111 in every mode.
